uart_frac_brg: RTL and testbench

//  Fractional-N baud rate generator for the UART, successor to tx_BRG. A phase

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_frac_brg_phase_acc.sv | 53 +++++
 rtl/uart_frac_brg.sv | 88 ++++++++
 tb/tb_uart_frac_brg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the baud increment calculator used by the
// fractional baud rate generator.
package uart_pkg;

  localparam int UART_OVERSAMPLE_DEF = 32'd16;
  localparam int UART_ACC_W_DEF      = 32'd32;

  // Rounded increment: baud*ovs*2^acc_w/clk_hz, half-up rounding.
  function automatic longint unsigned calc_baud_inc(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned ovs,
    input int unsigned     acc_w
  );
    longint unsigned num_v;
    num_v = (baud * ovs) << acc_w;
    return (num_v + (clk_hz / 64'd2)) / clk_hz;
  endfunction

endpackage

// File: rtl/uart_frac_brg_phase_acc.sv
// Phase accumulator with increment register; carry is qualified so that a
// load or clear in the same cycle suppresses it.
module brg_phase_acc
  import uart_pkg::*;
#(
  parameter int               ACC_W     = UART_ACC_W_DEF,
  parameter logic [ACC_W-1:0] RESET_INC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [ACC_W-1:0] load_val_i,
  output logic             carry_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W:0]   sum_s;

  assign sum_s = {1'b0, acc_q} + {1'b0, inc_q};

  // Next-state: load beats clear beats enable.
  always_comb begin
    acc_d   = acc_q;
    inc_d   = inc_q;
    carry_o = 1'b0;
    if (load_i) begin
      inc_d = load_val_i;
      acc_d = '0;
    end else if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d   = sum_s[ACC_W-1:0];
      carry_o = sum_s[ACC_W];
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator and increment registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      inc_q <= RESET_INC;
    end else begin
      acc_q <= acc_d;
      inc_q <= inc_d;
    end
  end

endmodule

// File: rtl/uart_frac_brg.sv
// Fractional-N UART baud rate generator: oversampled rx_tick, 1x tx_tick and
// the position of the current rx_tick within the bit.
module uart_frac_brg
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 32'd50_000_000,
  parameter int BAUD_RATE  = 32'd115_200,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int ACC_W      = UART_ACC_W_DEF,
  localparam int OS_W      = $clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             cfg_load,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic             cfg_ack,
  output logic             rx_tick,
  output logic             tx_tick,
  output logic [OS_W-1:0]  os_phase
);

  localparam longint unsigned DEFAULT_INC_W =
    calc_baud_inc(64'(CLOCK_FREQ), 64'(BAUD_RATE), 64'(OVERSAMPLE), ACC_W);
  localparam logic [ACC_W-1:0] DEFAULT_INC = DEFAULT_INC_W[ACC_W-1:0];
  localparam logic [OS_W-1:0]  OS_MAX      = OS_W'(OVERSAMPLE - 1);

  logic            carry_s;
  logic [OS_W-1:0] os_q, os_d;
  logic            rx_q, rx_d;
  logic            tx_q, tx_d;
  logic            ack_q, ack_d;

  brg_phase_acc #(
    .ACC_W     (ACC_W),
    .RESET_INC (DEFAULT_INC)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .clr_i      (sync_clr),
    .load_i     (cfg_load),
    .load_val_i (cfg_inc),
    .carry_o    (carry_s)
  );

  // Oversample counter and tick generation; carry is already gated by load/clear.
  always_comb begin
    os_d  = os_q;
    rx_d  = 1'b0;
    tx_d  = 1'b0;
    ack_d = 1'b0;
    if (cfg_load) begin
      os_d  = '0;
      ack_d = 1'b1;
    end else if (sync_clr) begin
      os_d = '0;
    end else if (carry_s) begin
      rx_d = 1'b1;
      tx_d = (os_q == OS_MAX);
      os_d = (os_q == OS_MAX) ? '0 : os_q + {{(OS_W-1){1'b0}}, 1'b1};
    end else begin
      os_d = os_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_q  <= '0;
      rx_q  <= 1'b0;
      tx_q  <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      os_q  <= os_d;
      rx_q  <= rx_d;
      tx_q  <= tx_d;
      ack_q <= ack_d;
    end
  end

  assign os_phase = os_q;
  assign rx_tick  = rx_q;
  assign tx_tick  = tx_q;
  assign cfg_ack  = ack_q;

endmodule

// File: tb/tb_uart_frac_brg.sv
// Self-checking bench for uart_frac_brg: cycle scoreboard plus directed
// timing checks on tick spacing, load, clear, freeze and async reset.
`timescale 1ns/1ps
module tb_uart_frac_brg;

  localparam logic [31:0] DEF_INC  = 32'd158329674;
  localparam logic [31:0] FAST_INC = 32'd633318698;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sync_clr = 1'b0;
  logic        cfg_load = 1'b0;
  logic [31:0] cfg_inc = 32'd0;
  logic        cfg_ack, rx_tick, tx_tick;
  logic [3:0]  os_phase;

  int vec_cnt = 0;
  int err_cnt = 0;

  uart_frac_brg dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .cfg_load (cfg_load),
    .cfg_inc  (cfg_inc),
    .cfg_ack  (cfg_ack),
    .rx_tick  (rx_tick),
    .tx_tick  (tx_tick),
    .os_phase (os_phase)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model of the generator, stepped once per clock.
  typedef struct packed {
    logic [31:0] acc;
    logic [31:0] inc;
    logic [3:0]  os;
    logic        rx;
    logic        tx;
    logic        ack;
  } mstate_t;

  function automatic mstate_t model_step(input mstate_t s, input logic ld, input logic clr,
                                         input logic e, input logic [31:0] ci);
    mstate_t     n;
    logic [32:0] sum;
    n = s;
    n.rx = 1'b0; n.tx = 1'b0; n.ack = 1'b0;
    sum = {1'b0, s.acc} + {1'b0, s.inc};
    if (ld) begin
      n.inc = ci; n.acc = 32'd0; n.os = 4'd0; n.ack = 1'b1;
    end else if (clr) begin
      n.acc = 32'd0; n.os = 4'd0;
    end else if (e) begin
      n.acc = sum[31:0];
      if (sum[32]) begin
        n.rx = 1'b1;
        n.tx = (s.os == 4'd15);
        n.os = (s.os == 4'd15) ? 4'd0 : s.os + 4'd1;
      end
    end
    return n;
  endfunction

  mstate_t    mdl;
  logic [6:0] sb[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl <= '{acc: 32'd0, inc: DEF_INC, os: 4'd0, rx: 1'b0, tx: 1'b0, ack: 1'b0};
      sb.delete();
    end else begin
      mstate_t n;
      n = model_step(mdl, cfg_load, sync_clr, en, cfg_inc);
      mdl <= n;
      sb.push_back({n.rx, n.tx, n.os, n.ack});
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out", {25'd0, rx_tick, tx_tick, os_phase, cfg_ack}, 32'd0);
    end else if (sb.size() > 0) begin
      logic [6:0] e;
      e = sb.pop_front();
      chk("cyc", {25'd0, rx_tick, tx_tick, os_phase, cfg_ack}, {25'd0, e});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until rx_tick (or tx_tick when want_tx) is seen; n = edges taken.
  task automatic wait_ev(input bit want_tx, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(want_tx ? tx_tick : rx_tick) && n < limit);
    if (n >= limit && !(want_tx ? tx_tick : rx_tick)) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n, tot, nrx, bad;
    logic [3:0] osv;

    // 1: reset and default rate
    repeat (3) step();
    chk("def_inc", dut.u_acc.inc_q, DEF_INC);
    rst_n = 1'b1; en = 1'b1;
    wait_ev(1'b0, 100, n);
    chk("first_rx_def", n, 32'd28);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      wait_ev(1'b0, 100, n);
      if (n != 27 && n != 28) bad++;
    end
    chk("rx_spacing", bad, 32'd0);
    wait_ev(1'b1, 1000, n);
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      wait_ev(1'b1, 1000, n);
      tot += n;
    end
    chk("tx10_in_window", ((tot * 20 >= 86790) && (tot * 20 <= 86830)) ? 32'd1 : 32'd0, 32'd1);

    // 2: runtime rate change
    cfg_inc = FAST_INC; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("ack", cfg_ack, 32'd1);
    wait_ev(1'b0, 100, n);
    chk("first_rx_fast", n, 32'd7);
    wait_ev(1'b1, 500, n);
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      wait_ev(1'b1, 500, n);
      tot += n;
    end
    chk("tx10_fast", (tot == 1085 || tot == 1086) ? 32'd1 : 32'd0, 32'd1);

    // 3: sync_clr mid-bit
    n = 0;
    while (!(rx_tick && os_phase == 4'd9) && n < 2000) begin step(); n++; end
    chk("reach_os9", os_phase, 32'd9);
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    chk("clr_no_tick", {rx_tick, tx_tick}, 32'd0);
    chk("clr_os", os_phase, 32'd0);
    nrx = 0;
    for (int i = 0; i < 20; i++) begin
      wait_ev(1'b0, 100, n);
      nrx++;
      if (tx_tick) break;
    end
    chk("rx_to_tx", nrx, 32'd16);

    // 4: freeze
    n = 0;
    while (!(rx_tick && os_phase == 4'd5) && n < 2000) begin step(); n++; end
    en = 1'b0;
    osv = os_phase;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rx_tick || tx_tick) bad++;
    end
    chk("freeze_ticks", bad, 32'd0);
    chk("freeze_os", os_phase, {28'd0, osv});
    en = 1'b1;
    repeat (200) step();

    // 5: zero increment, then load and clear together
    cfg_inc = 32'd0; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (rx_tick || tx_tick) bad++;
    end
    chk("idle_ticks", bad, 32'd0);
    cfg_inc = DEF_INC; cfg_load = 1'b1; sync_clr = 1'b1;
    step();
    cfg_load = 1'b0; sync_clr = 1'b0;
    chk("ack_win", cfg_ack, 32'd1);
    wait_ev(1'b0, 100, n);
    chk("load_wins", n, 32'd28);

    // 6: async reset during an rx_tick at the fast rate
    cfg_inc = FAST_INC; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    wait_ev(1'b0, 100, n);
    #5 rst_n = 1'b0;
    #1;
    chk("async_rst", {rx_tick, tx_tick, os_phase, cfg_ack}, 32'd0);
    chk("rst_inc", dut.u_acc.inc_q, DEF_INC);
    step(); step();
    rst_n = 1'b1;
    wait_ev(1'b0, 100, n);
    chk("post_rst_rx", n, 32'd28);
    repeat (100) step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
